cdb_writeback: RTL

CDB_WRITEBACK -- requirements
Module: cdb_writeback

---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/cdb_read_port.sv | 50 +++++
 rtl/cdb_writeback.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
//   Shared constants for the Tomasulo register file / common data bus slice.
//   TAG_W, DATA_W : default tag and data widths
//   N_REGS        : default number of architectural registers
//   FREE_REGISTER : tag value meaning "register holds a valid value"
//   RES_STATION_* : tags of the adder reservation stations
//   SEM_VALOR     : filler data value for operands not yet produced
package tomasulo_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int N_REGS = 8;

  localparam logic [TAG_W-1:0]  FREE_REGISTER    = 3'd0;
  localparam logic [TAG_W-1:0]  RES_STATION_ADD1 = 3'd1;
  localparam logic [TAG_W-1:0]  RES_STATION_ADD2 = 3'd2;
  localparam logic [DATA_W-1:0] SEM_VALOR        = 16'hFFF0;

  // A broadcast or allocation with the free tag carries no information.
  function automatic logic tag_is_live(input logic [TAG_W-1:0] tag);
    return tag != FREE_REGISTER;
  endfunction

endpackage

// File: rtl/cdb_read_port.sv
// cdb_read_port
//   One combinational source-operand read port of the register file with
//   same-cycle CDB forwarding.
//   Reset            : synchronous active-low reset; outputs read as reset state
//   Rd_Addr          : register to read
//   Reg_Data/Reg_Qi  : current register values and status tags
//   Cdb_Valid/Tag/Data : CDB broadcast in this cycle
//   Rd_Data/Rd_Qi    : operand value and producing tag (0 = value ready)
module cdb_read_port #(
  parameter int N_REGS = tomasulo_pkg::N_REGS,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic                           Reset,
  input  logic [ADDR_W-1:0]              Rd_Addr,
  input  logic [N_REGS-1:0][DATA_W-1:0]  Reg_Data,
  input  logic [N_REGS-1:0][TAG_W-1:0]   Reg_Qi,
  input  logic                           Cdb_Valid,
  input  logic [TAG_W-1:0]               Cdb_Tag,
  input  logic [DATA_W-1:0]              Cdb_Data,
  output logic [DATA_W-1:0]              Rd_Data,
  output logic [TAG_W-1:0]               Rd_Qi
);

  import tomasulo_pkg::*;

  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_qi;

  assign sel_data = Reg_Data[Rd_Addr];
  assign sel_qi   = Reg_Qi[Rd_Addr];

  always_comb begin
    Rd_Data = '0;
    Rd_Qi   = '0;
    // While reset is asserted the edge will clear everything, so present
    // the post-reset view instead of stale contents or a forwarded value.
    if (Reset) begin
      if (Cdb_Valid && Cdb_Tag != '0 && sel_qi == Cdb_Tag) begin
        Rd_Data = Cdb_Data;
        Rd_Qi   = '0;
      end else begin
        Rd_Data = sel_data;
        Rd_Qi   = sel_qi;
      end
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// cdb_writeback
//   Architectural register file plus register-status (Qi) table for a
//   Tomasulo core. Captures CDB broadcasts into every waiting register,
//   binds destination registers to station tags at dispatch, and serves
//   two forwarded source-operand reads.
//   Clock, Reset             : clock; synchronous active-low reset
//   Cdb_Valid/Tag/Data       : CDB broadcast from the arbiter
//   Alloc_En/Reg/Tag         : dispatch destination binding
//   Rd_Addr_J/K              : source operand addresses
//   Rd_Data_J/K, Rd_Qi_J/K   : Vj/Qj and Vk/Qk operand fields
//   Cdb_Ack / Cdb_Stale      : registered pulse, broadcast matched / matched nothing
//   Busy_Mask                : registered, bit i set when register i is pending
//   Wb_Count                 : saturating count of matching broadcast cycles
module cdb_writeback #(
  parameter int N_REGS = tomasulo_pkg::N_REGS,
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int ADDR_W = $clog2(N_REGS)
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Cdb_Valid,
  input  logic [TAG_W-1:0]   Cdb_Tag,
  input  logic [DATA_W-1:0]  Cdb_Data,
  input  logic               Alloc_En,
  input  logic [ADDR_W-1:0]  Alloc_Reg,
  input  logic [TAG_W-1:0]   Alloc_Tag,
  input  logic [ADDR_W-1:0]  Rd_Addr_J,
  input  logic [ADDR_W-1:0]  Rd_Addr_K,
  output logic [DATA_W-1:0]  Rd_Data_J,
  output logic [TAG_W-1:0]   Rd_Qi_J,
  output logic [DATA_W-1:0]  Rd_Data_K,
  output logic [TAG_W-1:0]   Rd_Qi_K,
  output logic               Cdb_Ack,
  output logic               Cdb_Stale,
  output logic [N_REGS-1:0]  Busy_Mask,
  output logic [7:0]         Wb_Count
);

  import tomasulo_pkg::*;

  logic [N_REGS-1:0][DATA_W-1:0] reg_data;
  logic [N_REGS-1:0][TAG_W-1:0]  reg_qi;

  logic [N_REGS-1:0][DATA_W-1:0] reg_data_nxt;
  logic [N_REGS-1:0][TAG_W-1:0]  reg_qi_nxt;
  logic [N_REGS-1:0]             match;
  logic [N_REGS-1:0]             busy_nxt;
  logic                          cdb_live;
  logic                          alloc_live;
  logic                          any_match;

  assign cdb_live   = Cdb_Valid && (Cdb_Tag != '0);
  assign alloc_live = Alloc_En && (Alloc_Tag != '0);
  assign any_match  = |match;

  always_comb begin
    match        = '0;
    reg_data_nxt = reg_data;
    reg_qi_nxt   = reg_qi;
    busy_nxt     = '0;
    for (int i = 0; i < N_REGS; i++) begin
      // Matches are taken against the pre-allocation status table.
      match[i] = cdb_live && (reg_qi[i] == Cdb_Tag);
      if (match[i]) begin
        reg_data_nxt[i] = Cdb_Data;
        reg_qi_nxt[i]   = '0;
      end
      // Allocation wins Qi on a collision: the station tag is being reused
      // for a new producer, while R still captures the retiring result.
      if (alloc_live && (Alloc_Reg == ADDR_W'(i))) begin
        reg_qi_nxt[i] = Alloc_Tag;
      end
      busy_nxt[i] = (reg_qi_nxt[i] != '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      reg_data  <= '0;
      reg_qi    <= '0;
      Cdb_Ack   <= 1'b0;
      Cdb_Stale <= 1'b0;
      Busy_Mask <= '0;
      Wb_Count  <= '0;
    end else begin
      reg_data  <= reg_data_nxt;
      reg_qi    <= reg_qi_nxt;
      Cdb_Ack   <= cdb_live && any_match;
      Cdb_Stale <= cdb_live && !any_match;
      Busy_Mask <= busy_nxt;
      if (cdb_live && any_match && (Wb_Count != 8'hFF)) begin
        Wb_Count <= Wb_Count + 8'd1;
      end
    end
  end

  cdb_read_port #(
    .N_REGS (N_REGS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_j (
    .Reset     (Reset),
    .Rd_Addr   (Rd_Addr_J),
    .Reg_Data  (reg_data),
    .Reg_Qi    (reg_qi),
    .Cdb_Valid (Cdb_Valid),
    .Cdb_Tag   (Cdb_Tag),
    .Cdb_Data  (Cdb_Data),
    .Rd_Data   (Rd_Data_J),
    .Rd_Qi     (Rd_Qi_J)
  );

  cdb_read_port #(
    .N_REGS (N_REGS),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_k (
    .Reset     (Reset),
    .Rd_Addr   (Rd_Addr_K),
    .Reg_Data  (reg_data),
    .Reg_Qi    (reg_qi),
    .Cdb_Valid (Cdb_Valid),
    .Cdb_Tag   (Cdb_Tag),
    .Cdb_Data  (Cdb_Data),
    .Rd_Data   (Rd_Data_K),
    .Rd_Qi     (Rd_Qi_K)
  );

endmodule
